// File: rtl/awg_param_ctrl.sv
// awg_param_ctrl: debounced four-key UI that edits the waveform generator parameters
// Ports: clk, rst_n (async active-low); key_mode/key_up/key_down/key_run raw keys;
// en, wave_sel, state_freq, state_amp, state_phase parameter registers;
// sel_field current edit field; update one-cycle pulse when a parameter changes.
module awg_param_ctrl #(
  parameter int DEB_CNT   = 20000,
  parameter int FREQ_MAX  = 4095,
  parameter int FREQ_DEF  = 1,
  parameter int AMP_DEF   = 4,
  parameter int PHASE_DEF = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_run,
  output logic        en,
  output logic [1:0]  wave_sel,
  output logic [11:0] state_freq,
  output logic [2:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic [1:0]  sel_field,
  output logic        update
);
  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [11:0] FMAX = 12'(FREQ_MAX);
  typedef enum logic [1:0] {F_FREQ, F_AMP, F_PHASE, F_WAVE} field_t;
  field_t state, state_n;
  logic [3:0] raw, s1, s2, deb, deb_d, evt;
  logic [CW-1:0] cnt [4];
  logic inc, dec, en_n, upd_n;
  logic [1:0] wave_n;
  logic [11:0] freq_n;
  logic [2:0] amp_n;
  logic [7:0] phase_n;
  assign raw = {key_run, key_down, key_up, key_mode};
  assign evt = deb & ~deb_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      deb_d <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      deb_d <= deb;
    end
  for (genvar g = 0; g < 4; g++) begin : g_deb
    // The level is accepted on the DEB_CNT-th consecutive differing cycle.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt[g] <= '0;
        deb[g] <= 1'b0;
      end else if (s2[g] == deb[g]) begin
        cnt[g] <= '0;
      end else if (cnt[g] == CW'(DEB_CNT - 1)) begin
        cnt[g] <= '0;
        deb[g] <= s2[g];
      end else begin
        cnt[g] <= cnt[g] + CW'(1);
      end
  end
  // A mode event or an up/down collision suppresses editing.
  assign inc = evt[1] & ~evt[2] & ~evt[0];
  assign dec = evt[2] & ~evt[1] & ~evt[0];
  always_comb begin
    state_n = evt[0] ? field_t'(state + 2'd1) : state;
    freq_n  = (state != F_FREQ) ? state_freq :
              (inc && state_freq != FMAX) ? state_freq + 12'd1 :
              (dec && state_freq > 12'd1) ? state_freq - 12'd1 : state_freq;
    amp_n   = (state != F_AMP) ? state_amp :
              (inc && state_amp != 3'd7) ? state_amp + 3'd1 :
              (dec && state_amp != 3'd0) ? state_amp - 3'd1 : state_amp;
    phase_n = (state != F_PHASE) ? state_phase :
              inc ? state_phase + 8'd1 : dec ? state_phase - 8'd1 : state_phase;
    wave_n  = (state != F_WAVE) ? wave_sel :
              inc ? wave_sel + 2'd1 : dec ? wave_sel - 2'd1 : wave_sel;
    en_n    = en ^ evt[3];
    upd_n   = evt[3] | (freq_n != state_freq) | (amp_n != state_amp) |
              (phase_n != state_phase) | (wave_n != wave_sel);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= F_FREQ;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en <= 1'b0;
      wave_sel <= '0;
      state_freq <= 12'(FREQ_DEF);
      state_amp <= 3'(AMP_DEF);
      state_phase <= 8'(PHASE_DEF);
      update <= 1'b0;
    end else begin
      en <= en_n;
      wave_sel <= wave_n;
      state_freq <= freq_n;
      state_amp <= amp_n;
      state_phase <= phase_n;
      update <= upd_n;
    end
  assign sel_field = state;
endmodule

// File: tb/tb_awg_param_ctrl.sv
// tb_awg_param_ctrl: directed self-checking bench for awg_param_ctrl
module tb_awg_param_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] keys = '0;
  logic en, update;
  logic [1:0] wave_sel, sel_field;
  logic [11:0] state_freq;
  logic [2:0] state_amp;
  logic [7:0] state_phase;
  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  localparam logic [3:0] M = 4'b0001, U = 4'b0010, D = 4'b0100, R = 4'b1000;
  awg_param_ctrl #(.DEB_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode(keys[0]), .key_up(keys[1]), .key_down(keys[2]), .key_run(keys[3]),
    .en(en), .wave_sel(wave_sel), .state_freq(state_freq), .state_amp(state_amp),
    .state_phase(state_phase), .sel_field(sel_field), .update(update)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (update) upd_cnt++;
  endtask
  task automatic press(input logic [3:0] m, input int n);
    keys = keys | m;
    repeat (n) tick();
    keys = keys & ~m;
    repeat (12) tick();
  endtask
  task automatic defaults(input string tag);
    chk({tag, "_en"}, 32'(en), 0);
    chk({tag, "_wave"}, 32'(wave_sel), 0);
    chk({tag, "_freq"}, 32'(state_freq), 1);
    chk({tag, "_amp"}, 32'(state_amp), 4);
    chk({tag, "_phase"}, 32'(state_phase), 0);
    chk({tag, "_sel"}, 32'(sel_field), 0);
    chk({tag, "_upd"}, 32'(update), 0);
  endtask
  initial begin
    #3 rst_n = 1'b0;
    repeat (3) tick();
    defaults("rst");
    rst_n = 1'b1;
    repeat (3) tick();
    defaults("post_rst");
    upd_cnt = 0;
    keys = U;
    repeat (6) tick();
    chk("lat_freq_e6", 32'(state_freq), 1);
    chk("lat_upd_e6", 32'(update), 0);
    tick();
    chk("lat_freq_e7", 32'(state_freq), 2);
    chk("lat_upd_e7", 32'(update), 1);
    tick();
    chk("lat_upd_e8", 32'(update), 0);
    repeat (50) tick();
    keys = '0;
    repeat (12) tick();
    chk("hold_freq", 32'(state_freq), 2);
    chk("hold_upd_cnt", 32'(upd_cnt), 1);
    upd_cnt = 0;
    press(D, 3);
    chk("glitch_freq", 32'(state_freq), 2);
    chk("glitch_upd", 32'(upd_cnt), 0);
    press(D, 6);
    chk("down_freq", 32'(state_freq), 1);
    chk("down_upd", 32'(upd_cnt), 1);
    upd_cnt = 0;
    press(D, 6);
    chk("freq_floor", 32'(state_freq), 1);
    chk("freq_floor_upd", 32'(upd_cnt), 0);
    press(M, 6);
    press(M, 6);
    chk("sel_phase", 32'(sel_field), 2);
    press(D, 6);
    chk("phase_wrap", 32'(state_phase), 255);
    chk("phase_keeps_freq", 32'(state_freq), 1);
    press(M, 6);
    chk("sel_wave", 32'(sel_field), 3);
    upd_cnt = 0;
    repeat (5) press(U, 6);
    chk("wave_wrap", 32'(wave_sel), 1);
    chk("wave_upd", 32'(upd_cnt), 5);
    press(M, 6);
    chk("sel_wrap", 32'(sel_field), 0);
    press(M, 6);
    chk("sel_amp", 32'(sel_field), 1);
    repeat (3) press(U, 6);
    chk("amp_7", 32'(state_amp), 7);
    upd_cnt = 0;
    press(U, 6);
    chk("amp_sat", 32'(state_amp), 7);
    chk("amp_sat_upd", 32'(upd_cnt), 0);
    press(U | D, 6);
    chk("updown_amp", 32'(state_amp), 7);
    chk("updown_upd", 32'(upd_cnt), 0);
    press(M | U, 6);
    chk("modeup_sel", 32'(sel_field), 2);
    chk("modeup_amp", 32'(state_amp), 7);
    chk("modeup_phase", 32'(state_phase), 255);
    chk("modeup_upd", 32'(upd_cnt), 0);
    press(R, 6);
    chk("run_en", 32'(en), 1);
    chk("run_upd", 32'(upd_cnt), 1);
    chk("run_wave", 32'(wave_sel), 1);
    keys = U;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    defaults("mid_rst");
    tick();
    keys = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    upd_cnt = 0;
    repeat (12) tick();
    chk("rst_freq", 32'(state_freq), 1);
    chk("rst_upd", 32'(upd_cnt), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
